// File: rtl/pmem_line_responder_if.sv
// -----------------------------------------------------------------------------
// pmem_line_responder_if
//
// Line-granular physical-memory bus between a cache/victim-cache controller
// (master) and the memory-side responder (slave).
//
// Signals:
//   pmem_read     master -> slave  line read request, held until pmem_resp
//   pmem_write    master -> slave  line write request, held until pmem_resp
//   pmem_address  master -> slave  16-bit byte address (bits [3:0] ignored)
//   pmem_wdata    master -> slave  128-bit write line
//   pmem_resp     slave -> master  one-cycle completion pulse
//   pmem_rdata    slave -> master  128-bit read line, valid with pmem_resp
// -----------------------------------------------------------------------------
interface pmem_line_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/pmem_line_responder.sv
// -----------------------------------------------------------------------------
// pmem_line_responder
//
// Memory-side endpoint of the line-granular pmem protocol. Holds DEPTH
// 128-bit lines, zero-fills them after reset, and answers each read or write
// request with a one-cycle pmem_resp pulse LATENCY cycles after acceptance.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high reset
//   pmem       pmem_line_responder_if.slave (request in, resp/rdata out)
//   busy       high while initialising or serving a request
//   proto_err  sticky: read and write seen together on an accepted request
//
// Parameters:
//   LATENCY    accept-to-resp cycles, 1..15
//   DEPTH      number of lines, power of two, 2..4096
//
// Optional feature (macro PMEM_RAND_LATENCY_EN): an 8-bit LFSR adds
// lfsr[2:0] extra cycles to each request's latency.
// -----------------------------------------------------------------------------
module pmem_line_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    pmem_line_responder_if.slave        pmem,
    output logic                        busy,
    output logic                        proto_err
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef PMEM_RAND_LATENCY_EN
    localparam int LAT_MAX = LATENCY + 7;
`else
    localparam int LAT_MAX = LATENCY;
`endif
    localparam int LAT_W = $clog2(LAT_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               op_write_q, op_write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       wdata_q, wdata_d;
    logic               proto_err_q, proto_err_d;

    logic [127:0]       mem_q [DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [127:0]       mem_wdata;

    logic [LAT_W-1:0]   eff_lat;
    logic               req;

    // Offset bits and aliasing upper bits are intentionally ignored.
    logic               unused_addr;
    assign unused_addr = ^pmem.pmem_address;

    assign req = pmem.pmem_read | pmem.pmem_write;

`ifdef PMEM_RAND_LATENCY_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] lfsr_next;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; low bits are sampled before stepping.
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign eff_lat   = LAT_W'(LATENCY) + LAT_W'(lfsr_q[2:0]);
`else
    assign eff_lat   = LAT_W'(LATENCY);
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            lat_cnt_q   <= '0;
            op_write_q  <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            proto_err_q <= 1'b0;
`ifdef PMEM_RAND_LATENCY_EN
            lfsr_q      <= 8'hA5;
`endif
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            lat_cnt_q   <= lat_cnt_d;
            op_write_q  <= op_write_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
`ifdef PMEM_RAND_LATENCY_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        lat_cnt_d   = lat_cnt_q;
        op_write_d  = op_write_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        proto_err_d = proto_err_q;
`ifdef PMEM_RAND_LATENCY_EN
        lfsr_d      = lfsr_q;
`endif
        unique case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req) begin
                    // Simultaneous read+write is served as a write.
                    op_write_d = pmem.pmem_write;
                    idx_d      = pmem.pmem_address[4 +: IDX_W];
                    wdata_d    = pmem.pmem_wdata;
                    lat_cnt_d  = eff_lat - 1'b1;
                    if (pmem.pmem_read && pmem.pmem_write) proto_err_d = 1'b1;
`ifdef PMEM_RAND_LATENCY_EN
                    lfsr_d     = lfsr_next;
`endif
                    state_d    = (eff_lat == LAT_W'(1)) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // lat_cnt starts at latency-1, so leaving on 1 puts resp
                // exactly latency cycles after the accept edge.
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q == LAT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs and storage write port.
    always_comb begin
        pmem.pmem_resp  = 1'b0;
        pmem.pmem_rdata = '0;
        busy            = 1'b1;
        mem_we          = 1'b0;
        mem_waddr       = init_ptr_q;
        mem_wdata       = '0;
        unique case (state_q)
            ST_INIT: mem_we = 1'b1;
            ST_IDLE: busy   = 1'b0;
            ST_WAIT: ;
            ST_RESP: begin
                pmem.pmem_resp = 1'b1;
                if (op_write_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx_q;
                    mem_wdata = wdata_q;
                end else begin
                    pmem.pmem_rdata = mem_q[idx_q];
                end
            end
            default: ;
        endcase
    end

    // NOTE: the line array has no reset branch; INIT zero-fills it one line
    // per cycle, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
    end

    assign proto_err = proto_err_q;

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Responder end of the line-granular physical-memory protocol that cache and victim-cache controllers drive through pmem_read, pmem_write, pmem_address and pmem_wdata, and that completes with pmem_resp and pmem_rdata.
- Holds a DEPTH-line backing store and answers each request after a programmable latency with a one-cycle pmem_resp pulse.
- Serves as the memory-side endpoint beneath the L1/victim hierarchy and as the bench memory for those blocks.

Parameters:
- LATENCY, 4, cycles from request acceptance to pmem_resp; legal range 1..15.
- DEPTH, 32, number of 128-bit lines stored; power of two, 2..4096.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pmem_read  input  1  line read request; held until pmem_resp.
- pmem_write  input  1  line write request; held until pmem_resp.
- pmem_address  input  16  byte address; bits [3:0] ignored; index = pmem_address[4 +: log2(DEPTH)]; upper bits alias.
- pmem_wdata  input  128  write line; sampled at acceptance.
- pmem_resp  output  1  one-cycle completion pulse.
- pmem_rdata  output  128  read line; valid only while pmem_resp=1 for a read.
- busy  output  1  high in INIT, WAIT and RESP.
- proto_err  output  1  sticky; set when pmem_read and pmem_write are sampled high together in IDLE.

Behaviour:
- Reset (synchronous, active-high): state=INIT, init_ptr=0, pmem_resp=0, pmem_rdata=0, busy=1, proto_err=0, lat_cnt=0. Reset mid-transaction aborts the transaction: no resp pulse and no array write.
- INIT: writes line init_ptr with 0 each cycle and increments init_ptr. After writing line DEPTH-1, goes to IDLE; busy drops on the first IDLE cycle. Requests are ignored during INIT and must stay held by the requester.
- IDLE:
  - On an edge where pmem_read|pmem_write=1, the request is accepted.
  - Captures op, index and pmem_wdata; sets lat_cnt=LATENCY-1.
  - Goes to RESP if LATENCY=1, otherwise to WAIT.
  - If both read and write are high: treated as a write and proto_err set to 1.
- WAIT: decrements lat_cnt each cycle; goes to RESP when lat_cnt reaches 1. This gives a resp pulse exactly LATENCY cycles after the accept edge.
- RESP:
  - pmem_resp=1 for exactly one cycle.
  - Read: pmem_rdata = array[captured index].
  - Write: array[captured index] <= captured wdata on the edge ending RESP; pmem_rdata is 0.
  - Then goes to IDLE.
- Changes to pmem_address or pmem_wdata after acceptance have no effect.
- Requester drops its request in the cycle after resp. A request still high in IDLE is a new transaction; this allows back-to-back requests with one IDLE cycle between them.
- Read-after-write to the same index returns the new data.
- Outside RESP, pmem_rdata is 0.
- proto_err is cleared only by reset.

Optional Feature:
- Macro: PMEM_RAND_LATENCY_EN.
- When defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset.
  - Advances once per accepted request.
  - Effective latency = LATENCY + lfsr[2:0], sampled before advancing; lat_cnt is sized for up to LATENCY+7.
- When undefined: no LFSR logic; latency is exactly LATENCY.

Test Plan:
- Reset then idle: busy=1 for 32 cycles after reset release; IDLE on cycle 33; pmem_resp=0 throughout. Read of address 16'h0040 returns 128'h0.
- Write then read (LATENCY=4):
  - Write 16'h0120 with data 128'hDEADBEEF_00000000_CAFEF00D_12345678; pmem_resp pulses 4 cycles after accept.
  - Read of 16'h012C returns the same line (offset ignored), with resp again 4 cycles after accept.
- Aliasing (DEPTH=32): write 16'h0010 with data A, then read 16'h0210; returns A, since index 1 aliases.
- Protocol error: read=write=1 at address 16'h0030 with data B. proto_err=1 from the next cycle and stays set; the write completes; a later read of 16'h0030 returns B.
- Reset mid-transaction: accept a write to 16'h0050, assert reset 2 cycles later. No pmem_resp; INIT rerun; a read of 16'h0050 returns 0.
- With PMEM_RAND_LATENCY_EN: the first accepted request after reset has resp at LATENCY+5 cycles (lfsr[2:0]=3'b101 from seed 8'hA5); successive latencies match the reference LFSR model.
